// File: rtl/imem_arbiter.sv
// Round-robin arbiter sharing one instruction memory between fetch (port 0) and loader (port 1).
// Optional IMEM_ARB_ALIGN_CHECK_EN: misaligned requests are consumed without access and answered with rsp_err.
module imem_arbiter #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_req_valid,
    output logic              p0_req_ready,
    input  logic [31:0]       p0_addr,
    input  logic              p0_flush,
    output logic              p0_rsp_valid,
    output logic [31:0]       p0_rdata,
`ifdef IMEM_ARB_ALIGN_CHECK_EN
    output logic              p0_rsp_err,
`endif
    input  logic              p1_req_valid,
    output logic              p1_req_ready,
    input  logic [31:0]       p1_addr,
    input  logic              p1_we,
    input  logic [31:0]       p1_wdata,
    input  logic              p1_lock,
    output logic              p1_rsp_valid,
    output logic [31:0]       p1_rdata,
`ifdef IMEM_ARB_ALIGN_CHECK_EN
    output logic              p1_rsp_err,
`endif
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rdata,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    output logic              arb_state_o
);

    // Request handshake: a request transfers in any cycle where valid and ready are both high;
    // responses are one-cycle pulses with no backpressure.
    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic        grant0, grant1;
    logic        mis0, mis1;
    logic        rsp0_q, rsp1_q;
    logic [31:0] rdata0_q, rdata1_q;

`ifdef IMEM_ARB_ALIGN_CHECK_EN
    logic err0_q, err1_q;
    assign mis0 = |p0_addr[1:0];
    assign mis1 = |p1_addr[1:0];
`else
    assign mis0 = 1'b0;
    assign mis1 = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant0       = 1'b0;
        grant1       = 1'b0;
        if (rst_n) begin
            case (state_q)
                ARB: begin
                    if (p0_req_valid && !p0_flush && p1_req_valid) begin
                        grant0 = last_grant_q;
                        grant1 = !last_grant_q;
                    end else begin
                        grant0 = p0_req_valid && !p0_flush;
                        grant1 = p1_req_valid;
                    end
                    if (p1_lock) state_d = LOCKED;
                end
                LOCKED: begin
                    grant1 = p1_req_valid;
                    if (!p1_lock) state_d = ARB;
                end
                default: state_d = ARB;
            endcase
            if (grant0)      last_grant_d = 1'b0;
            else if (grant1) last_grant_d = 1'b1;
        end
    end

    assign p0_req_ready = grant0;
    assign p1_req_ready = grant1;
    assign mem_addr     = grant1 ? p1_addr[ADDR_W+1:2] : p0_addr[ADDR_W+1:2];
    assign mem_we       = grant1 && p1_we && !mis1;
    assign mem_wdata    = p1_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ARB;
            last_grant_q <= 1'b1;
            rsp0_q       <= 1'b0;
            rsp1_q       <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            rsp0_q       <= grant0;
            rsp1_q       <= grant1;
            if (grant0) rdata0_q <= mis0 ? 32'h0 : mem_rdata;
            if (grant1) rdata1_q <= (p1_we || mis1) ? 32'h0 : mem_rdata;
        end
    end

`ifdef IMEM_ARB_ALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err0_q <= 1'b0;
            err1_q <= 1'b0;
        end else begin
            err0_q <= grant0 && mis0;
            err1_q <= grant1 && mis1;
        end
    end
    assign p0_rsp_err = err0_q && !p0_flush;
    assign p1_rsp_err = err1_q;
`endif

    // A redirect drops the in-flight fetch response rather than delaying it.
    assign p0_rsp_valid = rsp0_q && !p0_flush;
    assign p0_rdata     = rdata0_q;
    assign p1_rsp_valid = rsp1_q;
    assign p1_rdata     = rdata1_q;
    assign arb_state_o  = (state_q == LOCKED);

    logic unused_addr_bits;
    assign unused_addr_bits = ^{p0_addr[31:ADDR_W+2], p1_addr[31:ADDR_W+2],
                                p0_addr[1:0], p1_addr[1:0]};

endmodule

// File: tb/tb_imem_arbiter.sv
// Testbench for imem_arbiter: vector table with response scoreboard plus hand-written
// sequences for misaligned access, mid-flight reset and first-contention priority.
module tb_imem_arbiter;

    localparam int ADDR_W = 10;

    logic              clk;
    logic              rst_n;
    logic              p0_req_valid, p0_req_ready, p0_flush, p0_rsp_valid;
    logic [31:0]       p0_addr, p0_rdata;
    logic              p1_req_valid, p1_req_ready, p1_we, p1_lock, p1_rsp_valid;
    logic [31:0]       p1_addr, p1_wdata, p1_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_rdata, mem_wdata;
    logic              mem_we;
    logic              arb_state_o;
`ifdef IMEM_ARB_ALIGN_CHECK_EN
    logic              p0_rsp_err, p1_rsp_err;
`endif

    logic [31:0] mem     [0:(1<<ADDR_W)-1];
    logic [31:0] ref_mem [0:(1<<ADDR_W)-1];

    int checks = 0;
    int errors = 0;

    logic [31:0] exp0_q[$];
    logic [31:0] exp1_q[$];

    typedef struct {
        logic        p0v;
        logic [31:0] p0a;
        logic        fl;
        logic        p1v;
        logic        we;
        logic [31:0] p1a;
        logic [31:0] wd;
        logic        lk;
        logic        er0;
        logic        er1;
        logic        ewe;
    } vec_t;

    vec_t vecs[17];

    imem_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .p0_req_valid (p0_req_valid),
        .p0_req_ready (p0_req_ready),
        .p0_addr      (p0_addr),
        .p0_flush     (p0_flush),
        .p0_rsp_valid (p0_rsp_valid),
        .p0_rdata     (p0_rdata),
`ifdef IMEM_ARB_ALIGN_CHECK_EN
        .p0_rsp_err   (p0_rsp_err),
`endif
        .p1_req_valid (p1_req_valid),
        .p1_req_ready (p1_req_ready),
        .p1_addr      (p1_addr),
        .p1_we        (p1_we),
        .p1_wdata     (p1_wdata),
        .p1_lock      (p1_lock),
        .p1_rsp_valid (p1_rsp_valid),
        .p1_rdata     (p1_rdata),
`ifdef IMEM_ARB_ALIGN_CHECK_EN
        .p1_rsp_err   (p1_rsp_err),
`endif
        .mem_addr     (mem_addr),
        .mem_rdata    (mem_rdata),
        .mem_we       (mem_we),
        .mem_wdata    (mem_wdata),
        .arb_state_o  (arb_state_o)
    );

    // Clock / memory model
    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive_idle();
        p0_req_valid = 0; p0_addr = 0; p0_flush = 0;
        p1_req_valid = 0; p1_addr = 0; p1_we = 0; p1_wdata = 0; p1_lock = 0;
    endtask

    // Drive one vector at the falling edge, check outputs, update scoreboard.
    task automatic apply(input int i, input vec_t v);
        logic [31:0] e;
        @(negedge clk);
        p0_req_valid = v.p0v; p0_addr = v.p0a; p0_flush = v.fl;
        p1_req_valid = v.p1v; p1_we = v.we; p1_addr = v.p1a; p1_wdata = v.wd; p1_lock = v.lk;
        #1;
        chk($sformatf("v%0d p0_req_ready", i), {31'b0, p0_req_ready}, {31'b0, v.er0});
        chk($sformatf("v%0d p1_req_ready", i), {31'b0, p1_req_ready}, {31'b0, v.er1});
        chk($sformatf("v%0d mem_we", i), {31'b0, mem_we}, {31'b0, v.ewe});
        if (exp0_q.size() > 0) begin
            e = exp0_q.pop_front();
            chk($sformatf("v%0d p0_rsp_valid", i), {31'b0, p0_rsp_valid}, {31'b0, !v.fl});
            if (!v.fl) chk($sformatf("v%0d p0_rdata", i), p0_rdata, e);
        end else begin
            chk($sformatf("v%0d p0_rsp_valid idle", i), {31'b0, p0_rsp_valid}, 32'h0);
        end
        if (exp1_q.size() > 0) begin
            e = exp1_q.pop_front();
            chk($sformatf("v%0d p1_rsp_valid", i), {31'b0, p1_rsp_valid}, 32'h1);
            chk($sformatf("v%0d p1_rdata", i), p1_rdata, e);
        end else begin
            chk($sformatf("v%0d p1_rsp_valid idle", i), {31'b0, p1_rsp_valid}, 32'h0);
        end
        if (v.er0) exp0_q.push_back(ref_mem[v.p0a[ADDR_W+1:2]]);
        if (v.er1) begin
            if (v.we) begin
                exp1_q.push_back(32'h0);
                ref_mem[v.p1a[ADDR_W+1:2]] = v.wd;
            end else begin
                exp1_q.push_back(ref_mem[v.p1a[ADDR_W+1:2]]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) begin
            mem[i]     = 32'hA500_0000 | i;
            ref_mem[i] = 32'hA500_0000 | i;
        end
        mem[3]     = 32'hDEADBEEF;
        ref_mem[3] = 32'hDEADBEEF;

        //              p0v p0a    fl p1v we p1a    wd            lk  er0 er1 ewe
        vecs[0]  = '{1, 32'h10, 0, 1, 0, 32'h20, 32'h0,        0,  1, 0, 0};
        vecs[1]  = '{1, 32'h14, 0, 1, 0, 32'h24, 32'h0,        0,  0, 1, 0};
        vecs[2]  = '{1, 32'h18, 0, 1, 0, 32'h28, 32'h0,        0,  1, 0, 0};
        vecs[3]  = '{1, 32'h1C, 0, 1, 0, 32'h2C, 32'h0,        0,  0, 1, 0};
        vecs[4]  = '{0, 32'h0,  0, 0, 0, 32'h0,  32'h0,        0,  0, 0, 0};
        vecs[5]  = '{1, 32'h0C, 0, 0, 0, 32'h0,  32'h0,        0,  1, 0, 0};
        vecs[6]  = '{0, 32'h0,  0, 0, 0, 32'h0,  32'h0,        0,  0, 0, 0};
        vecs[7]  = '{0, 32'h0,  0, 0, 0, 32'h0,  32'h0,        0,  0, 0, 0};
        vecs[8]  = '{1, 32'h00, 0, 0, 0, 32'h0,  32'h0,        1,  1, 0, 0};
        vecs[9]  = '{1, 32'h04, 0, 1, 1, 32'h40, 32'h12345678, 1,  0, 1, 1};
        vecs[10] = '{1, 32'h04, 0, 1, 0, 32'h40, 32'h0,        1,  0, 1, 0};
        vecs[11] = '{1, 32'h04, 0, 0, 0, 32'h0,  32'h0,        0,  0, 0, 0};
        vecs[12] = '{1, 32'h40, 0, 0, 0, 32'h0,  32'h0,        0,  1, 0, 0};
        vecs[13] = '{0, 32'h0,  0, 0, 0, 32'h0,  32'h0,        0,  0, 0, 0};
        vecs[14] = '{1, 32'h08, 0, 0, 0, 32'h0,  32'h0,        0,  1, 0, 0};
        vecs[15] = '{1, 32'h0C, 1, 1, 0, 32'h10, 32'h0,        0,  0, 1, 0};
        vecs[16] = '{0, 32'h0,  0, 0, 0, 32'h0,  32'h0,        0,  0, 0, 0};

        // Reset state, with requests asserted to show readies are held low
        drive_idle();
        rst_n = 0;
        p0_req_valid = 1; p0_addr = 32'h0C;
        p1_req_valid = 1; p1_we = 1; p1_addr = 32'h40; p1_wdata = 32'h5555AAAA;
        #3;
        chk("rst p0_req_ready", {31'b0, p0_req_ready}, 32'h0);
        chk("rst p1_req_ready", {31'b0, p1_req_ready}, 32'h0);
        chk("rst mem_we", {31'b0, mem_we}, 32'h0);
        chk("rst p0_rsp_valid", {31'b0, p0_rsp_valid}, 32'h0);
        chk("rst p1_rsp_valid", {31'b0, p1_rsp_valid}, 32'h0);
        chk("rst p0_rdata", p0_rdata, 32'h0);
        chk("rst p1_rdata", p1_rdata, 32'h0);
        chk("rst state", {31'b0, arb_state_o}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        drive_idle();
        rst_n = 1;

        for (int i = 0; i < 17; i++) apply(i, vecs[i]);
        chk("mem word16 after locked write", mem[16], 32'h12345678);

`ifdef IMEM_ARB_ALIGN_CHECK_EN
        // Misaligned write is consumed but never reaches memory
        @(negedge clk);
        drive_idle();
        p1_req_valid = 1; p1_we = 1; p1_addr = 32'h41; p1_wdata = 32'hCAFEF00D;
        #1;
        chk("mis p1_req_ready", {31'b0, p1_req_ready}, 32'h1);
        chk("mis mem_we", {31'b0, mem_we}, 32'h0);
        @(negedge clk);
        drive_idle();
        #1;
        chk("mis p1_rsp_valid", {31'b0, p1_rsp_valid}, 32'h1);
        chk("mis p1_rsp_err", {31'b0, p1_rsp_err}, 32'h1);
        chk("mis p1_rdata", p1_rdata, 32'h0);
        chk("mis mem word16", mem[16], 32'h12345678);
`else
        // Misaligned read accesses the containing word
        @(negedge clk);
        drive_idle();
        p1_req_valid = 1; p1_addr = 32'h0D;
        #1;
        chk("mis p1_req_ready", {31'b0, p1_req_ready}, 32'h1);
        @(negedge clk);
        drive_idle();
        #1;
        chk("mis p1_rsp_valid", {31'b0, p1_rsp_valid}, 32'h1);
        chk("mis p1_rdata", p1_rdata, 32'hDEADBEEF);
`endif

        // Reset between grant and response; then p0 must win the first contention
        @(negedge clk);
        drive_idle();
        p0_req_valid = 1; p0_addr = 32'h0C;
        #1;
        chk("mid p0_req_ready", {31'b0, p0_req_ready}, 32'h1);
        @(posedge clk);
        #1;
        chk("mid p0_rsp_valid before reset", {31'b0, p0_rsp_valid}, 32'h1);
        drive_idle();
        #1;
        rst_n = 0;
        #1;
        chk("mid p0_rsp_valid after reset", {31'b0, p0_rsp_valid}, 32'h0);
        chk("mid p1_rsp_valid after reset", {31'b0, p1_rsp_valid}, 32'h0);
        chk("mid p0_rdata after reset", p0_rdata, 32'h0);
        p0_req_valid = 1; p0_addr = 32'h10;
        p1_req_valid = 1; p1_addr = 32'h20;
        #1;
        chk("mid p0_req_ready in reset", {31'b0, p0_req_ready}, 32'h0);
        chk("mid p1_req_ready in reset", {31'b0, p1_req_ready}, 32'h0);
        @(negedge clk);
        rst_n = 1;
        #1;
        chk("post state", {31'b0, arb_state_o}, 32'h0);
        chk("post p0 wins", {31'b0, p0_req_ready}, 32'h1);
        chk("post p1 loses", {31'b0, p1_req_ready}, 32'h0);
        @(negedge clk);
        drive_idle();
        #1;
        chk("post p0_rsp_valid", {31'b0, p0_rsp_valid}, 32'h1);
        chk("post p0_rdata", p0_rdata, ref_mem[4]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Shares the single instruction memory between two requesters: the core fetch stage (port 0, read-only) and the debug/program loader (port 1, read/write). It sits between the requesters and the memory's combinational read port and synchronous write port. It arbitrates round-robin per cycle, supports a loader lock for uninterrupted program loads, and returns registered read data exactly one cycle after the grant.

## Interface
- ADDR_W, 10, memory word-index width; the memory holds 2^ADDR_W words.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- p0_req_valid  in  1  fetch read request.
- p0_req_ready  out  1  fetch request accepted this cycle.
- p0_addr  in  32  fetch byte address.
- p0_flush  in  1  fetch redirect; cancels the outstanding fetch response.
- p0_rsp_valid  out  1  fetch read data valid.
- p0_rdata  out  32  fetch read data.
- p0_rsp_err  out  1  fetch response error; present only with IMEM_ARB_ALIGN_CHECK_EN.
- p1_req_valid  in  1  loader request.
- p1_req_ready  out  1  loader request accepted.
- p1_addr  in  32  loader byte address.
- p1_we  in  1  loader write; 0 means read.
- p1_wdata  in  32  loader write data.
- p1_lock  in  1  loader requests exclusive ownership.
- p1_rsp_valid  out  1  loader response valid; issued for reads and writes.
- p1_rdata  out  32  loader read data; 0 for writes.
- p1_rsp_err  out  1  loader response error; present only with the macro.
- mem_addr  out  ADDR_W  word index to the memory.
- mem_rdata  in  32  combinational read data from the memory.
- mem_we  out  1  memory write strobe.
- mem_wdata  out  32  memory write data.

## Operation
- Address translation: mem_addr = addr[ADDR_W+1:2]. Address bits [31:ADDR_W+2] are ignored, so out-of-range addresses wrap.
- State machine, reset state ARB:
  - ARB to LOCKED at a clock edge where p1_lock=1.
  - LOCKED to ARB at an edge where p1_lock=0.
- ARB state:
  - Only one port valid: that port is granted.
  - Both ports valid: the port not granted last time is granted.
  - last_grant resets to 1, so port 0 wins the first contention.
  - last_grant updates only on an actual grant.
- LOCKED state: p0_req_ready=0. p1_req_ready = p1_req_valid.
- p0_flush=1 blocks any grant to port 0 that cycle, and port 1 may be granted instead.
- Grant for port N: pN_req_ready=1, combinational from the valids, state and flush.
- Read grant:
  - mem_rdata is captured into that port's rdata register.
  - The rsp flag is set for the next cycle.
- Write grant:
  - mem_we=1 in the grant cycle; mem_wdata = p1_wdata.
  - p1_rsp_valid is set next cycle with p1_rdata=0.
  - mem_we is never asserted except for a granted port-1 write.
- p0_rsp_valid = rsp0_q & ~p0_flush, a combinational mask. A flushed response is dropped, not delayed.
- Responses have no backpressure; the requester must accept them.
- Reset mid-operation clears all response flags and drops any pending response.

## Timing
- Reset values:
  - p0_rsp_valid = p1_rsp_valid = 0; p0_rdata = p1_rdata = 0; rsp_err = 0.
  - state = ARB; last_grant = 1.
  - p0_req_ready = p1_req_ready = 0 and mem_we = 0 while rst_n=0.
- Latency: a grant in cycle N gives the response in cycle N+1 with the data read in cycle N.
- Throughput: one grant per cycle in total. Back-to-back grants to the same port are allowed.
- A write followed by a read of the same word in the next cycle returns the new data.
- When p1_lock rises, port 0 can still be granted in that same cycle, because the state is still ARB. The lock takes effect the following cycle.

## Configuration
- IMEM_ARB_ALIGN_CHECK_EN defined:
  - A granted request with addr[1:0]!=0 is still consumed (ready=1).
  - There is no memory access and mem_we stays 0.
  - The response comes next cycle with rdata=0 and rsp_err=1.
- Not defined:
  - addr[1:0] is ignored, so a misaligned address accesses the containing word.
  - The rsp_err ports do not exist.

## Test plan
- Reset with memory word 3 = 0xDEADBEEF, then p0 read at addr 0x0C: ready in cycle 0, p0_rsp_valid=1 with p0_rdata=0xDEADBEEF in cycle 1, no valid in cycle 2.
- Both ports continuously requesting reads of different words for 4 cycles after reset: grants alternate p0, p1, p0, p1, and each response matches its own address.
- p1_lock=1 and a p1 write of 0x12345678 to 0x40, with p0 requesting constantly: p0_req_ready=0 from the cycle after lock rises until the cycle after lock falls. Memory word 16 = 0x12345678. A following p0 read of 0x40 returns 0x12345678.
- p0 read granted in cycle N with p0_flush=1 in cycle N+1: p0_rsp_valid=0 in N+1 and no p0 grant in N+1. A p1 request in N+1 is granted.
- Assert rst_n=0 asynchronously between the grant and the response: both rsp_valid outputs go to 0 immediately, and after release state=ARB and p0 wins the first contention.
- With IMEM_ARB_ALIGN_CHECK_EN, p1 write to 0x41: mem_we stays 0, p1_rsp_err=1 the next cycle, and memory is unchanged.
